// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester and transmitter signals around the UART TX arbiter.
// The arbiter sits on the slave side; the surrounding system is the master.
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  owner;
  logic        err;

  modport master (
    output req, req_data, tx_busy,
    input  grant, tx_start, tx_data, owner, err
  );

  modport slave (
    input  req, req_data, tx_busy,
    output grant, tx_start, tx_data, owner, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters,
// with a bounded wait for the transmitter to acknowledge each start pulse.
module uart_tx_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TMO  = 16
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned CntW = (TMO > 2) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      grant_q, grant_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [1:0]      owner_q, owner_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;

  // Search starts one past the last owner; the 2-bit add wraps modulo four.
  always_comb begin
    winner = owner_q;
    idx    = owner_q;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = owner_q + 2'(k);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found && !bus.tx_busy) begin
          grant_d   = 4'b0001 << winner;
          tx_data_d = bus.req_data[{winner, 3'b000} +: 8];
          owner_d   = winner;
          state_d   = StStart;
        end
      end
      StStart: begin
        // Registered so the start pulse follows the grant pulse without overlap.
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(TMO - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!bus.tx_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Owner resets to 3 so that requester 0 is searched first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      owner_q    <= 2'd3;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      owner_q    <= owner_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.owner    = owner_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle-level expectations derived from transfer
// timing arithmetic, directed vectors, corner sequences and random traffic.
module tb_uart_tx_arbiter;

  localparam int Tmo = 16;
  localparam int Far = 32'h3fff_0000;

  logic clk = 1'b0;
  logic reset;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .NREQ(4),
    .TMO (Tmo)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          d;
    int          l;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic [7:0]  txd;
    logic        err;
  } vec_t;

  vec_t vecs [9];
  logic [3:0] fair_exp [5];

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;

  // Stimulus state.
  logic [3:0]  tb_req;
  logic [31:0] tb_data;
  logic        manual_busy, next_rst, rand_mode, auto_drop;
  int          cur_d, cur_l;

  // Reference model state: what was presented at the last edge, plus the
  // cycle numbers at which each phase of the current transfer is due.
  logic [3:0]  prev_req;
  logic [31:0] prev_data;
  logic        prev_busy, prev_run;
  logic [1:0]  m_owner;
  logic [7:0]  m_data;
  int          idle_from, start_c, err_c, busy_on, busy_off;

  logic [3:0] seen_grant;
  logic       seen_err;

  function automatic int rr_pick(input logic [3:0] r, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (int'(last) + k) % 4;
      if (r[j]) return j;
    end
    return int'(last);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = 2'd3;
    m_data    = 8'h00;
    idle_from = t;
    start_c   = Far;
    err_c     = Far;
    busy_on   = Far;
    busy_off  = Far;
  endtask

  task automatic step();
    logic [3:0] exp_grant;
    int w;
    @(negedge clk);
    t++;
    exp_grant = '0;
    if (prev_run && !prev_busy && prev_req != 4'b0 && t - 1 >= idle_from) begin
      w         = rr_pick(prev_req, m_owner);
      exp_grant = 4'(1 << w);
      m_owner   = 2'(w);
      m_data    = prev_data[8*w +: 8];
      if (rand_mode) begin
        cur_d = $urandom_range(1, 20);
        cur_l = $urandom_range(1, 8);
      end
      start_c = t + 1;
      if (cur_d >= Tmo) begin
        err_c     = start_c + Tmo;
        idle_from = err_c;
        busy_on   = Far;
        busy_off  = Far;
      end else begin
        err_c     = Far;
        busy_on   = start_c + cur_d;
        busy_off  = busy_on + cur_l;
        idle_from = busy_off + 1;
      end
    end
    chk("grant", 32'(bus.grant), 32'(exp_grant));
    chk("tx_start", 32'(bus.tx_start), 32'(t == start_c));
    chk("err", 32'(bus.err), 32'(t == err_c));
    chk("owner", 32'(bus.owner), 32'(m_owner));
    chk("tx_data", 32'(bus.tx_data), 32'(m_data));
    if (bus.grant != 4'b0 && seen_grant == 4'b0) seen_grant = bus.grant;
    if (bus.err) seen_err = 1'b1;

    if (auto_drop) tb_req = tb_req & ~exp_grant;
    if (rand_mode) begin
      for (int i = 0; i < 4; i++) begin
        if (!tb_req[i] && !exp_grant[i] && $urandom_range(0, 3) == 0) begin
          tb_req[i]          = 1'b1;
          tb_data[8*i +: 8]  = 8'($urandom);
        end
      end
    end
    if (!next_rst) model_reset();
    reset        = next_rst;
    bus.req      = tb_req;
    bus.req_data = tb_data;
    bus.tx_busy  = manual_busy | (t >= busy_on && t < busy_off);
    prev_req     = tb_req;
    prev_data    = tb_data;
    prev_busy    = bus.tx_busy;
    prev_run     = next_rst;
    if (!next_rst) begin
      #1;
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd3);
      chk("rst_err", 32'(bus.err), 32'd0);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && t <= idle_from + 1; i++) step();
  endtask

  task automatic wait_grant();
    seen_grant = '0;
    for (int i = 0; i < 40 && seen_grant == 4'b0; i++) step();
  endtask

  initial begin
    vecs[0] = '{4'b0100, 32'h00A5_0000,  2, 10, 4'b0100, 2'd2, 8'hA5, 1'b0};
    vecs[1] = '{4'b1111, 32'h4433_2211,  3,  4, 4'b1000, 2'd3, 8'h44, 1'b0};
    vecs[2] = '{4'b1001, 32'h9900_0077,  1,  1, 4'b0001, 2'd0, 8'h77, 1'b0};
    vecs[3] = '{4'b1001, 32'h9900_0077,  1,  1, 4'b1000, 2'd3, 8'h99, 1'b0};
    vecs[4] = '{4'b0010, 32'h0000_5A00, 20,  1, 4'b0010, 2'd1, 8'h5A, 1'b1};
    vecs[5] = '{4'b0011, 32'h0000_C3B2,  2,  2, 4'b0001, 2'd0, 8'hB2, 1'b0};
    vecs[6] = '{4'b0110, 32'h00E1_F000,  2,  2, 4'b0010, 2'd1, 8'hF0, 1'b0};
    vecs[7] = '{4'b1000, 32'h3C00_0000, 15,  2, 4'b1000, 2'd3, 8'h3C, 1'b0};
    vecs[8] = '{4'b0001, 32'h0000_0081, 16,  1, 4'b0001, 2'd0, 8'h81, 1'b1};
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    tb_req      = '0;
    tb_data     = '0;
    manual_busy = 1'b0;
    next_rst    = 1'b0;
    rand_mode   = 1'b0;
    auto_drop   = 1'b1;
    cur_d       = 2;
    cur_l       = 3;
    seen_grant  = '0;
    seen_err    = 1'b0;
    model_reset();
    prev_req     = '0;
    prev_data    = '0;
    prev_busy    = 1'b0;
    prev_run     = 1'b0;
    reset        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_busy  = 1'b0;

    repeat (3) step();
    next_rst = 1'b1;
    step();

    // All four held high after reset: service order 0,1,2,3,0.
    auto_drop = 1'b0;
    tb_req    = 4'b1111;
    tb_data   = 32'h4433_2211;
    cur_d     = 1;
    cur_l     = 2;
    for (int n = 0; n < 5; n++) begin
      wait_grant();
      chk("fair_order", 32'(seen_grant), 32'(fair_exp[n]));
    end
    tb_req    = '0;
    auto_drop = 1'b1;
    wait_idle();

    for (int v = 0; v < 9; v++) begin
      tb_req   = vecs[v].req;
      tb_data  = vecs[v].data;
      cur_d    = vecs[v].d;
      cur_l    = vecs[v].l;
      seen_err = 1'b0;
      wait_grant();
      tb_req = '0;
      chk("vec_grant", 32'(seen_grant), 32'(vecs[v].grant));
      chk("vec_owner", 32'(bus.owner), 32'(vecs[v].owner));
      chk("vec_tx_data", 32'(bus.tx_data), 32'(vecs[v].txd));
      wait_idle();
      chk("vec_err", 32'(seen_err), 32'(vecs[v].err));
    end

    // Transmitter busy while idle holds off the grant until it drops.
    manual_busy = 1'b1;
    step();
    tb_req     = 4'b0010;
    tb_data    = 32'h0000_6600;
    cur_d      = 2;
    cur_l      = 3;
    seen_grant = '0;
    repeat (6) step();
    chk("busy_block", 32'(seen_grant), 32'd0);
    chk("busy_owner", 32'(bus.owner), 32'd0);
    manual_busy = 1'b0;
    step();
    step();
    chk("busy_release", 32'(seen_grant), 32'(4'b0010));
    wait_idle();

    // Reset while the transmitter is shifting: requester 0 must win afterwards
    // even though round-robin from owner 2 would pick requester 3.
    tb_req  = 4'b0100;
    tb_data = 32'h5500_3366;
    cur_d   = 1;
    cur_l   = 20;
    wait_grant();
    chk("mid_grant", 32'(seen_grant), 32'(4'b0100));
    tb_req = 4'b1001;
    repeat (5) step();
    next_rst = 1'b0;
    step();
    next_rst   = 1'b1;
    seen_grant = '0;
    step();
    step();
    chk("rst_first", 32'(seen_grant), 32'(4'b0001));
    chk("rst_first_data", 32'(bus.tx_data), 32'h66);
    tb_req = '0;
    wait_idle();

    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    tb_req    = '0;
    wait_idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing one UART transmitter (fixed at 4 for this release).
REQ-002 Parameter: TMO, 16, maximum cycles to wait for tx_busy to rise after tx_start.
REQ-003 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; when low, all state is forced to reset values immediately.
REQ-005 Port: req  input  4  bit i high = requester i has a byte pending; held until granted.
REQ-006 Port: req_data  input  32  byte of requester i on bits [8i+7:8i]; stable while req[i] is high.
REQ-007 Port: grant  output  4  one-hot, one-cycle pulse; byte of that requester accepted.
REQ-008 Port: tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-009 Port: tx_data  output  8  byte to transmit; stable from grant until return to IDLE.
REQ-010 Port: tx_busy  input  1  transmitter is shifting a frame.
REQ-011 Port: owner  output  2  index of the most recently granted requester.
REQ-012 Port: err  output  1  one-cycle pulse on handshake timeout.

Function
REQ-013 The FSM SHALL have states IDLE, START, WAIT_BUSY and WAIT_DONE, all registered.
REQ-014 IDLE: if req != 0 and tx_busy == 0 at an edge, that edge SHALL select the winner, latch its byte into tx_data, pulse grant, update owner and enter START; otherwise remain in IDLE.
REQ-015 Winner selection SHALL be round-robin: search starts at index (owner+1) mod 4 and wraps upward; the first set req bit wins.
REQ-016 START: tx_start SHALL be high for exactly this one cycle, the next edge entering WAIT_BUSY, and the timeout counter SHALL clear.
REQ-017 WAIT_BUSY: tx_busy == 1 SHALL move to WAIT_DONE; otherwise the counter SHALL increment, and on reaching TMO-1 the FSM SHALL pulse err for one cycle and return to IDLE.
REQ-018 WAIT_DONE: tx_busy == 0 SHALL return to IDLE; there is no timeout in this state.
REQ-019 Latency: req set at IDLE edge N -> grant high in cycle N+1, tx_start high in cycle N+2; earliest next grant is one cycle after tx_busy falls.
REQ-020 grant and tx_start SHALL never be high in the same cycle; at most one grant bit SHALL be high.
REQ-021 req SHALL be sampled only in IDLE; requests raised or dropped in other states SHALL have no effect until IDLE.
REQ-022 tx_busy already high in IDLE SHALL block all grants, leaving owner unchanged.
REQ-023 A requester that drops req after grant and re-raises it SHALL be served only after all other pending requesters (round-robin fairness).
REQ-024 owner SHALL change only on a grant; tx_data SHALL change only on a grant.

Reset
REQ-025 With reset low: state = IDLE, grant = 0, tx_start = 0, tx_data = 8'h00, owner = 2'd3 (so requester 0 has first priority), err = 0, timeout counter = 0.
REQ-026 Reset asserted mid-transfer SHALL abort immediately without a tx_start or grant pulse; after release the FSM SHALL start in IDLE and re-arbitrate from requester 0.

Verification
REQ-027 Single request: req=4'b0100, req_data[23:16]=8'hA5, tx_busy rises 2 cycles after tx_start and is high 10 cycles -> grant=4'b0100 one cycle, tx_data=8'hA5, tx_start one cycle later, owner=2, back in IDLE one cycle after tx_busy falls.
REQ-028 Fairness: req=4'b1111 held, each transfer completes normally -> grant order 0,1,2,3,0 after reset.
REQ-029 Wrap: owner=3, req=4'b1001 -> requester 0 granted; next grant goes to 3.
REQ-030 Timeout: tx_busy held 0 after tx_start -> err pulses once 16 cycles after WAIT_BUSY entry, FSM returns to IDLE, no further tx_start for that byte.
REQ-031 Busy block: tx_busy=1 in IDLE with req=4'b0010 -> no grant until tx_busy=0, then grant=4'b0010 on the next edge.
REQ-032 Reset mid-WAIT_DONE: reset low for 1 cycle -> all outputs at REQ-025 values at once, pending requester 0 granted first after release.
